// File: rtl/acc_cutoff_pkg.sv
// Shared widths, output limits and the round/ReLU/saturate helper used by the
// accumulate-and-cutoff stages behind the conv adder trees.
package acc_cutoff_pkg;

  localparam int unsigned IN_LEN  = 20;
  localparam int unsigned ACC_LEN = 32;
  localparam int unsigned OUT_LEN = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SH_W    = 5;

  localparam logic signed [OUT_LEN-1:0] OUT_MAX = {1'b0, {(OUT_LEN-1){1'b1}}};
  localparam logic signed [OUT_LEN-1:0] OUT_MIN = {1'b1, {(OUT_LEN-1){1'b0}}};

  typedef struct packed {
    logic                      sat;
    logic signed [OUT_LEN-1:0] data;
  } cut_res_t;

  // Round half-up toward +inf, arithmetic shift, optional ReLU, clip to OUT_LEN.
  function automatic cut_res_t sat_round(input logic signed [ACC_LEN-1:0] value,
                                         input logic [SH_W-1:0]           shift,
                                         input logic                      relu);
    logic signed [ACC_LEN:0] ext;
    logic signed [ACC_LEN:0] rnd;
    logic signed [ACC_LEN:0] r;
    cut_res_t                res;
    ext = (ACC_LEN+1)'(value);
    rnd = '0;
    if (shift != '0) rnd = (ACC_LEN+1)'(1) << (shift - SH_W'(1));
    r = (ext + rnd) >>> shift;
    if (relu && r[ACC_LEN]) r = '0;
    res.sat  = 1'b0;
    res.data = r[OUT_LEN-1:0];
    if (r > (ACC_LEN+1)'(OUT_MAX)) begin
      res.sat  = 1'b1;
      res.data = OUT_MAX;
    end else if (r < (ACC_LEN+1)'(OUT_MIN)) begin
      res.sat  = 1'b1;
      res.data = OUT_MIN;
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_cutoff_if.sv
// Partial-sum input stream, group config and feature-map output stream.
interface acc_cutoff_if;
  import acc_cutoff_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [IN_LEN-1:0]  in_data;
  logic [CNT_W-1:0]          cfg_ch_num;
  logic [SH_W-1:0]           cfg_shift;
  logic                      cfg_relu;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_LEN-1:0] out_data;
  logic                      out_sat;

  modport master (
    output in_valid, in_data, cfg_ch_num, cfg_shift, cfg_relu, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, cfg_ch_num, cfg_shift, cfg_relu, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/acc_cutoff_round_sat.sv
// Combinational cutoff: round, shift, ReLU and saturate a wide sum.
module acc_cutoff_round_sat
  import acc_cutoff_pkg::*;
(
  input  logic signed [ACC_LEN-1:0] value,
  input  logic [SH_W-1:0]           shift,
  input  logic                      relu,
  output logic signed [OUT_LEN-1:0] data_c,
  output logic                      sat_c
);

  cut_res_t res;

  assign res    = sat_round(value, shift, relu);
  assign data_c = res.data;
  assign sat_c  = res.sat;

endmodule

// File: rtl/acc_cutoff.sv
// Accumulates cfg_ch_num partial sums per output, then rounds/saturates the
// completed sum onto a valid/ready output toward the feature-map writer.
module acc_cutoff
  import acc_cutoff_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  acc_cutoff_if.slave bus
);

  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          lat_n;
  logic [SH_W-1:0]           lat_shift;
  logic                      lat_relu;
  logic signed [ACC_LEN-1:0] acc;

  logic                      fin_valid;
  logic signed [ACC_LEN-1:0] fin_sum;
  logic [SH_W-1:0]           fin_shift;
  logic                      fin_relu;

  logic                      out_valid;
  logic signed [OUT_LEN-1:0] out_data;
  logic                      out_sat;

  logic [CNT_W-1:0]          grp_n;
  logic [SH_W-1:0]           grp_shift;
  logic                      grp_relu;
  logic                      cnt_is_last;
  logic                      fin_move;
  logic                      in_ready_c;
  logic                      accept;
  logic signed [ACC_LEN-1:0] acc_next;
  logic signed [OUT_LEN-1:0] cut_data_c;
  logic                      cut_sat_c;

  // The first beat of a group uses live config; later beats use the latched copy.
  always_comb begin
    grp_n       = lat_n;
    grp_shift   = lat_shift;
    grp_relu    = lat_relu;
    if (cnt == '0) begin
      grp_n     = bus.cfg_ch_num;
      grp_shift = bus.cfg_shift;
      grp_relu  = bus.cfg_relu;
    end
    cnt_is_last = (grp_n <= CNT_W'(1)) ? (cnt == '0) : (cnt == grp_n - CNT_W'(1));
    fin_move    = fin_valid && (!out_valid || bus.out_ready);
    in_ready_c  = !(cnt_is_last && fin_valid && !fin_move);
    accept      = bus.in_valid && in_ready_c;
    acc_next    = ((cnt == '0) ? ACC_LEN'(0) : acc) + ACC_LEN'(bus.in_data);
  end

  acc_cutoff_round_sat u_round_sat (
    .value  (fin_sum),
    .shift  (fin_shift),
    .relu   (fin_relu),
    .data_c (cut_data_c),
    .sat_c  (cut_sat_c)
  );

  // Stage A: accumulate; the finished sum carries its own shift/relu so a new
  // group may start while it waits for the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_n     <= '0;
      lat_shift <= '0;
      lat_relu  <= 1'b0;
      acc       <= '0;
      fin_valid <= 1'b0;
      fin_sum   <= '0;
      fin_shift <= '0;
      fin_relu  <= 1'b0;
    end else begin
      if (accept) begin
        if (cnt == '0) begin
          lat_n     <= bus.cfg_ch_num;
          lat_shift <= bus.cfg_shift;
          lat_relu  <= bus.cfg_relu;
        end
        if (cnt_is_last) begin
          fin_sum   <= acc_next;
          fin_shift <= grp_shift;
          fin_relu  <= grp_relu;
          cnt       <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (accept && cnt_is_last) fin_valid <= 1'b1;
      else if (fin_move)         fin_valid <= 1'b0;
    end
  end

  // Stage B: output register, held stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (fin_move) begin
      out_valid <= 1'b1;
      out_data  <= cut_data_c;
      out_sat   <= cut_sat_c;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_sat   = out_sat;

endmodule
